// File: rtl/i2c_byte_ctrl.sv
// Byte-level I2C master sequencer: START / STOP / WRITE / READ on 4-phase bit slots.
// Line drive is open-drain style: *_oe = 1 pulls the line low.
module i2c_byte_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd,
    input  logic [7:0] wr_data,
    input  logic       tx_nack,
    output logic [7:0] rd_data,
    output logic       rx_nack,
    output logic       done,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i
);
    typedef enum logic [2:0] {IDLE, START, STOP, WRITE, READ, FIN} state_t;

    state_t      state, state_n;
    logic [3:0]  slot, slot_n;
    logic [1:0]  phase, phase_n;
    logic        bad, bad_n;
    logic [7:0]  wbyte, sr;
    logic        txn, ack_q;
    logic        accept, op, last, load;
    logic [1:0]  lines_n;

    assign cmd_ready = (state == IDLE) && !bad;
    assign accept    = cmd_valid && cmd_ready;
    assign op        = (state == START) || (state == STOP) ||
                       (state == WRITE) || (state == READ);
    assign busy      = op || bad;
    assign done      = (state == FIN);
    assign last      = (state == START) || (state == STOP) || (slot == 4'd8);

    // {scl_oe, sda_oe} for a given phase of a given slot
    function automatic logic [1:0] levels(state_t st, logic [3:0] sl,
                                          logic [1:0] ph, logic [7:0] wb,
                                          logic tn);
        logic d;
        d = 1'b0;
        if (st == WRITE && sl < 4'd8) d = ~wb[3'd7 - sl[2:0]];
        if (st == READ && sl == 4'd8) d = ~tn;
        case (st)
            START:   levels = {ph == 2'd3, ph[1]};
            STOP:    levels = {ph == 2'd0, ph != 2'd3};
            default: levels = {(ph == 2'd0) || (ph == 2'd3), d};
        endcase
    endfunction

    always_comb begin
        state_n = state;
        slot_n  = slot;
        phase_n = phase;
        bad_n   = bad;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (bad) begin
                    bad_n   = 1'b0;
                    state_n = FIN;
                end else if (accept) begin
                    slot_n  = 4'd0;
                    phase_n = 2'd0;
                    load    = 1'b1;
                    case (cmd)
                        3'd1:    state_n = START;
                        3'd2:    state_n = STOP;
                        3'd3:    state_n = WRITE;
                        3'd4:    state_n = READ;
                        default: begin
                            bad_n = 1'b1;
                            load  = 1'b0;
                        end
                    endcase
                end
            end
            FIN: state_n = IDLE;
            default: begin
                if (tick) begin
                    if (phase == 2'd3) begin
                        if (last) begin
                            state_n = FIN;
                            slot_n  = 4'd0;
                            phase_n = 2'd0;
                        end else begin
                            slot_n  = slot + 4'd1;
                            phase_n = 2'd0;
                            load    = 1'b1;
                        end
                    end else begin
                        phase_n = phase + 2'd1;
                        load    = 1'b1;
                    end
                end
            end
        endcase
        lines_n = levels(state_n, slot_n, phase_n,
                         accept ? wr_data : wbyte,
                         accept ? tx_nack : txn);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            slot    <= 4'd0;
            phase   <= 2'd0;
            bad     <= 1'b0;
            scl_oe  <= 1'b0;
            sda_oe  <= 1'b0;
            wbyte   <= 8'h00;
            txn     <= 1'b0;
            sr      <= 8'h00;
            ack_q   <= 1'b0;
            rd_data <= 8'h00;
            rx_nack <= 1'b0;
        end else begin
            state <= state_n;
            slot  <= slot_n;
            phase <= phase_n;
            bad   <= bad_n;
            if (load) {scl_oe, sda_oe} <= lines_n;
            if (accept) begin
                wbyte <= wr_data;
                txn   <= tx_nack;
            end
            // SDA is sampled on the tick that closes the SCL-high window
            if (tick && phase == 2'd2) begin
                if (state == WRITE && slot == 4'd8) ack_q <= sda_i;
                if (state == READ && slot < 4'd8) sr <= {sr[6:0], sda_i};
            end
            if (state_n == FIN && state == WRITE) rx_nack <= ack_q;
            if (state_n == FIN && state == READ)  rd_data <= sr;
        end
    end
endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// Randomised bench for i2c_byte_ctrl against a per-phase line-level model.
// Expected levels come from the START/STOP/data-bit tables and the byte to send.
module tb_i2c_byte_ctrl;
    logic       clk = 1'b0;
    logic       reset, tick, cmd_valid, cmd_ready;
    logic [2:0] cmd;
    logic [7:0] wr_data, rd_data;
    logic       tx_nack, rx_nack, done, busy, scl_oe, sda_oe, sda_i;

    int errors = 0;
    int checks = 0;
    logic [7:0] m_rd;
    logic       m_rxn, m_scl, m_sda;

    always #5 clk = ~clk;

    i2c_byte_ctrl dut (
        .clk(clk), .reset(reset), .tick(tick), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd(cmd), .wr_data(wr_data),
        .tx_nack(tx_nack), .rd_data(rd_data), .rx_nack(rx_nack),
        .done(done), .busy(busy), .scl_oe(scl_oe), .sda_oe(sda_oe),
        .sda_i(sda_i)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // k = number of counted ticks since acceptance; bits[8-s] = 1 means SDA released in slot s
    function automatic logic [1:0] exp_lines(logic [2:0] c, int k, logic [8:0] bits);
        int p;
        p = k % 4;
        if (c == 3'd1) return (p < 2) ? 2'b00 : (p == 2) ? 2'b01 : 2'b11;
        if (c == 3'd2) return (p == 0) ? 2'b11 : (p == 3) ? 2'b00 : 2'b01;
        return {(p == 0 || p == 3), ~bits[8 - k / 4]};
    endfunction

    task automatic do_cmd(input logic [2:0] c, input logic [7:0] data,
                          input logic txn, input logic [7:0] slave,
                          input logic ack, input int gmin, input int gmax,
                          input bit coincide, input bit hold, input int abort_at);
        int nt;
        logic [8:0] bits;
        logic [1:0] e;
        logic [12:0] got, want;
        nt = (c == 3'd3 || c == 3'd4) ? 36 : 4;
        bits = (c == 3'd3) ? {data, 1'b1} : {8'hFF, txn};
        cmd_valid = 1'b1; cmd = c; wr_data = data; tx_nack = txn;
        tick = coincide;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready cmd=%0d got=%b want=1", c, cmd_ready);
        end
        step();
        tick = 1'b0;
        if (hold) begin
            cmd = 3'd7; wr_data = 8'($urandom); tx_nack = 1'($urandom);
        end else cmd_valid = 1'b0;
        sda_i = (c == 3'd4) ? slave[7] : 1'($urandom);
        e = exp_lines(c, 0, bits);
        checks++;
        if ({scl_oe, sda_oe, busy, done, cmd_ready} !== {e, 3'b100}) begin
            errors++;
            $display("FAIL ph0 cmd=%0d got=%b want=%b", c,
                     {scl_oe, sda_oe, busy, done, cmd_ready}, {e, 3'b100});
        end
        for (int k = 1; k <= nt; k++) begin
            tick = 1'b0;
            repeat ($urandom_range(gmax, gmin)) step();
            tick = 1'b1;
            step();
            tick = 1'b0;
            if (k == nt) break;
            e = exp_lines(c, k, bits);
            got  = {scl_oe, sda_oe, busy, done, cmd_ready, rd_data};
            want = {e, 3'b100, m_rd};
            checks++;
            if (got !== want || rx_nack !== m_rxn) begin
                errors++;
                $display("FAIL tick%0d cmd=%0d got=%h/%b want=%h/%b", k, c,
                         got, rx_nack, want, m_rxn);
            end
            if (k == abort_at) return;
            if (k % 4 == 0) begin
                if (c == 3'd4 && k / 4 < 8) sda_i = slave[7 - k / 4];
                else if (c == 3'd3 && k / 4 == 8) sda_i = ack;
                else sda_i = 1'($urandom);
            end
        end
        if (c == 3'd3) m_rxn = ack;
        if (c == 3'd4) m_rd = slave;
        {m_scl, m_sda} = exp_lines(c, nt - 1, bits);
        got  = {scl_oe, sda_oe, busy, done, cmd_ready, rd_data};
        want = {m_scl, m_sda, 3'b010, m_rd};
        checks++;
        if (got !== want || rx_nack !== m_rxn) begin
            errors++;
            $display("FAIL fin cmd=%0d got=%h/%b want=%h/%b", c,
                     got, rx_nack, want, m_rxn);
        end
        cmd_valid = 1'b0;
        step();
        want = {m_scl, m_sda, 3'b001, m_rd};
        got  = {scl_oe, sda_oe, busy, done, cmd_ready, rd_data};
        checks++;
        if (got !== want || rx_nack !== m_rxn) begin
            errors++;
            $display("FAIL idle_after cmd=%0d got=%h/%b want=%h/%b", c,
                     got, rx_nack, want, m_rxn);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_rd = 8'h00; m_rxn = 1'b0; m_scl = 1'b0; m_sda = 1'b0;
        checks++;
        if ({scl_oe, sda_oe, cmd_ready, busy, done, rd_data, rx_nack} !== 13'b00100_00000000_0) begin
            errors++;
            $display("FAIL reset got=%b want=0010000000000",
                     {scl_oe, sda_oe, cmd_ready, busy, done, rd_data, rx_nack});
        end
    endtask

    task automatic test_start();
        do_cmd(3'd1, 8'h00, 1'b0, 8'h00, 1'b0, 29, 29, 0, 0, 0);
    endtask

    task automatic test_write();
        do_cmd(3'd3, 8'hA5, 1'b0, 8'h00, 1'b0, 0, 3, 0, 0, 0);
    endtask

    task automatic test_read();
        do_cmd(3'd4, 8'h00, 1'b1, 8'h3C, 1'b0, 0, 3, 0, 0, 0);
    endtask

    task automatic test_sequence();
        do_cmd(3'd1, 8'h00, 1'b0, 8'h00, 1'b0, 0, 2, 0, 1, 0);
        do_cmd(3'd3, 8'($urandom), 1'b0, 8'h00, 1'b1, 0, 2, 0, 1, 0);
        do_cmd(3'd2, 8'h00, 1'b0, 8'h00, 1'b0, 0, 2, 0, 1, 0);
    endtask

    task automatic test_illegal();
        cmd_valid = 1'b1; cmd = 3'd7; wr_data = 8'($urandom);
        step();
        cmd_valid = 1'b0;
        tick = 1'b1;
        checks++;
        if ({busy, done, cmd_ready, scl_oe, sda_oe} !== {3'b100, m_scl, m_sda}) begin
            errors++;
            $display("FAIL illegal_1 got=%b want=%b",
                     {busy, done, cmd_ready, scl_oe, sda_oe}, {3'b100, m_scl, m_sda});
        end
        step();
        tick = 1'b0;
        checks++;
        if ({busy, done, cmd_ready, scl_oe, sda_oe, rd_data, rx_nack} !==
            {3'b010, m_scl, m_sda, m_rd, m_rxn}) begin
            errors++;
            $display("FAIL illegal_done got=%b want=%b",
                     {busy, done, cmd_ready, scl_oe, sda_oe, rd_data, rx_nack},
                     {3'b010, m_scl, m_sda, m_rd, m_rxn});
        end
        step();
        checks++;
        if ({busy, done, cmd_ready} !== 3'b001) begin
            errors++;
            $display("FAIL illegal_idle got=%b want=001", {busy, done, cmd_ready});
        end
    endtask

    task automatic test_coincide();
        do_cmd(3'd1, 8'h00, 1'b0, 8'h00, 1'b0, 1, 4, 1, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++)
            do_cmd(3'($urandom_range(4, 1)), 8'($urandom), 1'($urandom),
                   8'($urandom), 1'($urandom), 0, 2, 1'($urandom), 0, 0);
    endtask

    task automatic test_reset_mid();
        do_cmd(3'd3, 8'($urandom), 1'b0, 8'h00, 1'b1, 0, 2, 0, 0, 18);
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_rd = 8'h00; m_rxn = 1'b0; m_scl = 1'b0; m_sda = 1'b0;
        checks++;
        if ({scl_oe, sda_oe, cmd_ready, busy, done} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_mid got=%b want=00100",
                     {scl_oe, sda_oe, cmd_ready, busy, done});
        end
        for (int i = 0; i < 8; i++) begin
            tick = 1'(i % 2);
            step();
            checks++;
            if ({done, busy, cmd_ready} !== 3'b001) begin
                errors++;
                $display("FAIL reset_mid_quiet%0d got=%b want=001", i,
                         {done, busy, cmd_ready});
            end
        end
        tick = 1'b0;
        do_cmd(3'd1, 8'h00, 1'b0, 8'h00, 1'b0, 0, 3, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; cmd_valid = 1'b0; cmd = 3'd0;
        wr_data = 8'h00; tx_nack = 1'b0; sda_i = 1'b1;
        step();
        step();
        test_reset();
        test_start();
        test_write();
        test_read();
        test_sequence();
        test_illegal();
        test_coincide();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
